// File: rtl/motor602_seq_ctrl.sv
// motor602_seq_ctrl: ramps the three-phase motor core's command inputs from run/direction/setpoint requests.
//   clkI, nRstI              : 1 MHz clock, asynchronous active-low reset
//   runReqI, dirReqI, estopI : level requests (run, rotation direction, emergency stop)
//   freqTgtI, pwrTgtI        : frequency / power level setpoints
//   m3startO, m3forceStopO, m3invRotateO                  : level commands to the motor core
//   m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo      : one-cycle step pulses to the motor core
//   freqLvlO, pwrLvlO        : levels issued so far (net INC minus DEC)
//   stateO, busyO            : state encoding, not-idle flag
module motor602_seq_ctrl #(
    parameter int STEP_DIV = 1000,
    parameter int DWELL    = 200,
    parameter int LVL_W    = 8
) (
    input  logic             clkI,
    input  logic             nRstI,
    input  logic             runReqI,
    input  logic             dirReqI,
    input  logic             estopI,
    input  logic [LVL_W-1:0] freqTgtI,
    input  logic [LVL_W-1:0] pwrTgtI,
    output logic             m3startO,
    output logic             m3forceStopO,
    output logic             m3invRotateO,
    output logic             m3freqINCo,
    output logic             m3freqDECo,
    output logic             m3powerINCo,
    output logic             m3powerDECo,
    output logic [LVL_W-1:0] freqLvlO,
    output logic [LVL_W-1:0] pwrLvlO,
    output logic [2:0]       stateO,
    output logic             busyO
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_TRACK = 3'd2,
        S_DOWN  = 3'd3,
        S_DWELL = 3'd4,
        S_ESTOP = 3'd5
    } state_t;

    localparam int PW = $clog2(STEP_DIV);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t        state;
    logic [PW-1:0] pre_cnt;
    logic [DW-1:0] dwell_cnt;
    logic          tick;
    logic          f_up, f_dn, p_up, p_dn;

    assign tick   = pre_cnt == PW'(STEP_DIV - 1);
    // Comparing against the target bounds each step, so levels cannot wrap.
    assign f_up   = freqLvlO < freqTgtI;
    assign f_dn   = freqLvlO > freqTgtI;
    assign p_up   = pwrLvlO < pwrTgtI;
    assign p_dn   = pwrLvlO > pwrTgtI;
    assign stateO = state;
    assign busyO  = state != S_IDLE;

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) pre_cnt <= '0;
        else        pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state        <= S_IDLE;
            dwell_cnt    <= '0;
            m3startO     <= 1'b0;
            m3forceStopO <= 1'b0;
            m3invRotateO <= 1'b0;
            m3freqINCo   <= 1'b0;
            m3freqDECo   <= 1'b0;
            m3powerINCo  <= 1'b0;
            m3powerDECo  <= 1'b0;
            freqLvlO     <= '0;
            pwrLvlO      <= '0;
        end else begin
            m3freqINCo  <= 1'b0;
            m3freqDECo  <= 1'b0;
            m3powerINCo <= 1'b0;
            m3powerDECo <= 1'b0;
            if (estopI) begin
                // Emergency stop ignores the prescaler and beats a coincident tick.
                state        <= S_ESTOP;
                dwell_cnt    <= '0;
                m3forceStopO <= 1'b1;
                m3startO     <= 1'b0;
                freqLvlO     <= '0;
                pwrLvlO      <= '0;
            end else if (tick) begin
                case (state)
                    S_IDLE: if (runReqI) begin
                        m3invRotateO <= dirReqI;
                        m3startO     <= 1'b1;
                        state        <= S_START;
                    end
                    // Leaving START takes the first step, so its pulse appears once TRACK is visible.
                    S_START, S_TRACK: if (state == S_TRACK && (!runReqI || dirReqI != m3invRotateO)) begin
                        state <= S_DOWN;
                    end else begin
                        state       <= S_TRACK;
                        m3freqINCo  <= f_up;
                        m3freqDECo  <= f_dn;
                        m3powerINCo <= p_up;
                        m3powerDECo <= p_dn;
                        freqLvlO    <= f_up ? freqLvlO + LVL_W'(1) : f_dn ? freqLvlO - LVL_W'(1) : freqLvlO;
                        pwrLvlO     <= p_up ? pwrLvlO + LVL_W'(1) : p_dn ? pwrLvlO - LVL_W'(1) : pwrLvlO;
                    end
                    S_DOWN: if (freqLvlO == '0 && pwrLvlO == '0) begin
                        m3startO  <= 1'b0;
                        dwell_cnt <= '0;
                        state     <= (runReqI && dirReqI != m3invRotateO) ? S_DWELL : S_IDLE;
                    end else begin
                        m3freqDECo  <= |freqLvlO;
                        m3powerDECo <= |pwrLvlO;
                        freqLvlO    <= (|freqLvlO) ? freqLvlO - LVL_W'(1) : freqLvlO;
                        pwrLvlO     <= (|pwrLvlO) ? pwrLvlO - LVL_W'(1) : pwrLvlO;
                    end
                    S_DWELL: if (!runReqI) begin
                        dwell_cnt <= '0;
                        state     <= S_IDLE;
                    end else if (dwell_cnt == DW'(DWELL - 1)) begin
                        dwell_cnt    <= '0;
                        m3invRotateO <= dirReqI;
                        m3startO     <= 1'b1;
                        state        <= S_START;
                    end else begin
                        dwell_cnt <= dwell_cnt + DW'(1);
                    end
                    // A held run request must be dropped before the motor may restart.
                    S_ESTOP: if (!runReqI) begin
                        m3forceStopO <= 1'b0;
                        state        <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_motor602_seq_ctrl.sv
// tb_motor602_seq_ctrl: directed self-checking bench for motor602_seq_ctrl (STEP_DIV=4, DWELL=2, LVL_W=8).
module tb_motor602_seq_ctrl;
    logic       clk = 1'b0;
    logic       nRstI = 1'b0;
    logic       runReqI = 1'b0, dirReqI = 1'b0, estopI = 1'b0;
    logic [7:0] freqTgtI = '0, pwrTgtI = '0;
    logic       m3startO, m3forceStopO, m3invRotateO;
    logic       m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo;
    logic [7:0] freqLvlO, pwrLvlO;
    logic [2:0] stateO;
    logic       busyO;
    int         tests = 0, failed = 0;
    int         cyc = 0;

    motor602_seq_ctrl #(.STEP_DIV(4), .DWELL(2), .LVL_W(8)) dut (
        .clkI(clk), .nRstI(nRstI), .runReqI(runReqI), .dirReqI(dirReqI), .estopI(estopI),
        .freqTgtI(freqTgtI), .pwrTgtI(pwrTgtI),
        .m3startO(m3startO), .m3forceStopO(m3forceStopO), .m3invRotateO(m3invRotateO),
        .m3freqINCo(m3freqINCo), .m3freqDECo(m3freqDECo),
        .m3powerINCo(m3powerINCo), .m3powerDECo(m3powerDECo),
        .freqLvlO(freqLvlO), .pwrLvlO(pwrLvlO), .stateO(stateO), .busyO(busyO)
    );

    always #5 clk = ~clk;

    // Edges since reset release; registered outputs move on edges that are multiples of 4.
    always @(posedge clk or negedge nRstI) cyc <= !nRstI ? 0 : cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle1();
        @(posedge clk);
        #1;
    endtask

    task automatic next_tick();
        do cycle1(); while (cyc % 4 != 0);
    endtask

    // {fINC, fDEC, pINC, pDEC}
    function automatic logic [3:0] pulses();
        return {m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo};
    endfunction

    initial begin
        // 1. Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            runReqI  = 1'($urandom);
            dirReqI  = 1'($urandom);
            estopI   = 1'($urandom);
            freqTgtI = 8'($urandom);
            pwrTgtI  = 8'($urandom);
            cycle1();
            chk("reset_outs", {m3startO, m3forceStopO, m3invRotateO, pulses(), freqLvlO, pwrLvlO, stateO, busyO}, 32'd0);
        end
        runReqI = 1'b0; dirReqI = 1'b0; estopI = 1'b0; freqTgtI = 8'd3; pwrTgtI = 8'd2;
        @(posedge clk); #1;
        nRstI = 1'b1;
        // 2. Start-up ramp; first tick lands on edge 4 after release
        runReqI = 1'b1;
        repeat (3) cycle1();
        chk("no_tick_before_4", {m3startO, stateO}, {1'b0, 3'd0});
        next_tick();
        chk("t1_start", {m3startO, stateO, busyO, pulses()}, {1'b1, 3'd1, 1'b1, 4'b0000});
        next_tick();
        chk("t2_pulses", pulses(), 4'b1010);
        chk("t2_lvls", {stateO, freqLvlO, pwrLvlO}, {3'd2, 8'd1, 8'd1});
        cycle1();
        chk("pulse_width", pulses(), 4'b0000);
        next_tick();
        chk("t3_pulses", pulses(), 4'b1010);
        next_tick();
        chk("t4_pulses", pulses(), 4'b1000);
        chk("t4_lvls", {freqLvlO, pwrLvlO}, {8'd3, 8'd2});
        next_tick();
        chk("ramp_done", {pulses(), stateO, freqLvlO, pwrLvlO}, {4'b0000, 3'd2, 8'd3, 8'd2});
        // 3. Setpoint decrease 3 -> 1
        freqTgtI = 8'd1;
        next_tick();
        chk("dec1", {pulses(), freqLvlO}, {4'b0100, 8'd2});
        next_tick();
        chk("dec2", {pulses(), freqLvlO}, {4'b0100, 8'd1});
        next_tick();
        chk("dec_hold", {pulses(), freqLvlO, pwrLvlO}, {4'b0000, 8'd1, 8'd2});
        freqTgtI = 8'd3;
        repeat (2) next_tick();
        chk("restore", {freqLvlO, pwrLvlO}, {8'd3, 8'd2});
        // 4. Reversal
        dirReqI = 1'b1;
        next_tick();
        chk("rev_down", {stateO, pulses(), freqLvlO, pwrLvlO, m3startO}, {3'd3, 4'b0000, 8'd3, 8'd2, 1'b1});
        next_tick();
        chk("rev_d1", {pulses(), freqLvlO, pwrLvlO}, {4'b0101, 8'd2, 8'd1});
        next_tick();
        chk("rev_d2", {pulses(), freqLvlO, pwrLvlO}, {4'b0101, 8'd1, 8'd0});
        next_tick();
        chk("rev_d3", {pulses(), freqLvlO, pwrLvlO}, {4'b0100, 8'd0, 8'd0});
        next_tick();
        chk("rev_dwell", {stateO, m3startO, pulses()}, {3'd4, 1'b0, 4'b0000});
        next_tick();
        chk("rev_dwell2", {stateO, m3startO, m3invRotateO}, {3'd4, 1'b0, 1'b0});
        next_tick();
        chk("rev_restart", {stateO, m3startO, m3invRotateO}, {3'd1, 1'b1, 1'b1});
        repeat (3) next_tick();
        chk("rev_reramp", {stateO, freqLvlO, pwrLvlO}, {3'd2, 8'd3, 8'd2});
        // 6. Stop request with a coincident direction change: ramp down, then IDLE
        runReqI = 1'b0; dirReqI = 1'b0;
        next_tick();
        chk("stop_down", stateO, 3'd3);
        next_tick();
        chk("stop_d1", pulses(), 4'b0101);
        next_tick();
        chk("stop_d2", pulses(), 4'b0101);
        next_tick();
        chk("stop_d3", {pulses(), freqLvlO, pwrLvlO}, {4'b0100, 8'd0, 8'd0});
        next_tick();
        chk("stop_idle", {m3startO, busyO, stateO}, {1'b0, 1'b0, 3'd0});
        // 5. Emergency stop coinciding with a tick, mid-ramp at level 2
        runReqI = 1'b1; dirReqI = 1'b1;
        repeat (3) next_tick();
        chk("es_pre", {freqLvlO, pwrLvlO, m3invRotateO}, {8'd2, 8'd2, 1'b1});
        repeat (3) cycle1();
        estopI = 1'b1;
        cycle1();
        chk("es_enter", {m3forceStopO, m3startO, pulses(), freqLvlO, pwrLvlO, stateO, busyO},
            {1'b1, 1'b0, 4'b0000, 8'd0, 8'd0, 3'd5, 1'b1});
        estopI = 1'b0;
        next_tick();
        chk("es_hold_run", {stateO, m3forceStopO, m3startO}, {3'd5, 1'b1, 1'b0});
        runReqI = 1'b0;
        next_tick();
        chk("es_exit", {stateO, m3forceStopO, busyO}, {3'd0, 1'b0, 1'b0});
        // Reset asserted mid-ramp
        runReqI = 1'b1; freqTgtI = 8'd3; pwrTgtI = 8'd2;
        repeat (2) next_tick();
        chk("rst_pre", {stateO, freqLvlO}, {3'd2, 8'd1});
        #2 nRstI = 1'b0;
        #1;
        chk("rst_mid", {m3startO, m3forceStopO, m3invRotateO, pulses(), freqLvlO, pwrLvlO, stateO, busyO}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
